reprodutor_sequencia: RTL and testbench
=======================================

REPRODUTOR_SEQUENCIA -- requirements
Module: reprodutor_sequencia

Interface
REQ-001 The block SHALL have parameter T_ON, default 3'd? no: default 1000, meaning the number of clock cycles each sequence LED word is lit (1..65535).
REQ-002 The block SHALL have parameter T_OFF, default 500, meaning the number of blank clock cycles after each word (1..65535).
REQ-003 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port iniciar, input, 1 bit: single-cycle start pulse.
REQ-006 The block SHALL have port abortar, input, 1 bit: synchronous abort request.
REQ-007 The block SHALL have port limite, input, 4 bits: index of the last word to play (0..15).
REQ-008 The block SHALL have port mem_endereco, output, 4 bits: read address to the sequence memory.
REQ-009 The block SHALL have port mem_dado, input, 7 bits: sequence memory read data, valid one cycle after the address is presented.
REQ-010 The block SHALL have port leds, output, 7 bits: player LED drive.
REQ-011 The block SHALL have port ocupado, output, 1 bit: high whenever the state is not OCIOSO.
REQ-012 The block SHALL have port pronto, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port db_estado, output, 5 bits: state code for the estado7seg debug display.

Function
REQ-014 The block SHALL implement states OCIOSO=0, ENDERECA=1, LE=2, ACENDE=3, APAGA=4, FIM=5 on db_estado; any other code SHALL go to OCIOSO on the next edge.
REQ-015 In OCIOSO, iniciar=1 SHALL latch limite into an internal register, clear the address counter to 0, and go to ENDERECA.
REQ-016 ENDERECA SHALL last one cycle, drive mem_endereco with the address counter, and go to LE.
REQ-017 LE SHALL last one cycle, load mem_dado into a 7-bit data register on the exit edge, clear the 16-bit timer, and go to ACENDE.
REQ-018 ACENDE SHALL drive leds with the data register for exactly T_ON cycles, then clear the timer and go to APAGA.
REQ-019 APAGA SHALL drive leds=0 for exactly T_OFF cycles and then branch on the address counter.
REQ-020 On leaving APAGA, if the address counter equals the latched limite, the state SHALL go to FIM; otherwise the address counter SHALL increment by 1 and the state SHALL go to ENDERECA.
REQ-021 FIM SHALL assert pronto for exactly one cycle and then return to OCIOSO.
REQ-022 leds SHALL be 0 in every state except ACENDE.
REQ-023 Each word SHALL occupy exactly 2+T_ON+T_OFF cycles.
REQ-024 pronto SHALL rise (limite+1)*(2+T_ON+T_OFF) cycles after the edge that samples iniciar.
REQ-025 A word value of 0 SHALL still consume its full time slot, with leds=0.
REQ-026 iniciar SHALL be ignored in every state except OCIOSO.
REQ-027 Changes to limite after the start SHALL have no effect on the sequence in progress.
REQ-028 abortar=1 in any state other than OCIOSO SHALL force OCIOSO on the next edge with leds=0, and SHALL NOT generate a pronto pulse.
REQ-029 abortar SHALL take priority over every other transition, including a simultaneous iniciar.
REQ-030 The address counter SHALL NOT wrap; limite=15 SHALL play addresses 0..15 and then go to FIM.
REQ-031 mem_endereco SHALL equal the address counter in all states.

Reset
REQ-032 While reset=0, the block SHALL immediately force state OCIOSO, address counter 0, data register 0, timer 0, latched limite 0, leds=0, pronto=0, ocupado=0, db_estado=0.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence with no pronto pulse.
REQ-034 After reset is released, the block SHALL accept iniciar starting from the next rising edge.

Verification (T_ON=3, T_OFF=2 for all scenarios)
REQ-035 Scenario: memory {0x01, 0x40}, limite=1, iniciar pulse -> leds=0x01 for 3 cycles, 0 for 4 cycles, leds=0x40 for 3 cycles, then pronto high exactly 14 cycles after iniciar is sampled, for 1 cycle.
REQ-036 Scenario: limite=0, memory[0]=0x7F -> one 7-cycle slot, pronto at cycle 7, mem_endereco stays 0.
REQ-037 Scenario: iniciar pulsed again during ACENDE, and limite changed to 5 mid-run -> timing and word count identical to REQ-035.
REQ-038 Scenario: abortar during the second ACENDE -> next cycle state=0, leds=0, ocupado=0, and no pronto for at least 20 cycles.
REQ-039 Scenario: reset=0 asynchronously mid-APAGA, between clock edges -> all outputs 0 immediately; after release, a new run behaves as in REQ-035.
REQ-040 Scenario: limite=15 with memory[i]=i -> 16 slots, addresses 0..15 in order, pronto at cycle 112, no wrap to 0 before FIM.

Source files
------------

// File: rtl/reprodutor_sequencia.sv
// Sequence player: reads up to 16 LED words from a synchronous memory and
// shows each one for T_ON cycles followed by T_OFF blank cycles.
module reprodutor_sequencia #(
  parameter int unsigned T_ON  = 1000,
  parameter int unsigned T_OFF = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [3:0] limite,
  output logic [3:0] mem_endereco,
  input  logic [6:0] mem_dado,
  output logic [6:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [4:0] db_estado
);

  typedef enum logic [4:0] {
    OCIOSO   = 5'd0,
    ENDERECA = 5'd1,
    LE       = 5'd2,
    ACENDE   = 5'd3,
    APAGA    = 5'd4,
    FIM      = 5'd5
  } estado_t;

  localparam logic [15:0] TON_ULT  = 16'(T_ON - 1);
  localparam logic [15:0] TOFF_ULT = 16'(T_OFF - 1);

  estado_t     estado;
  logic [3:0]  endereco;
  logic [3:0]  limite_reg;
  logic [6:0]  dado;
  logic [15:0] timer;

  assign mem_endereco = endereco;
  assign db_estado    = estado;
  assign ocupado      = (estado != OCIOSO);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= OCIOSO;
      endereco   <= 4'd0;
      limite_reg <= 4'd0;
      dado       <= 7'd0;
      timer      <= 16'd0;
      leds       <= 7'd0;
      pronto     <= 1'b0;
    end else if (abortar && estado != OCIOSO) begin
      estado <= OCIOSO;
      leds   <= 7'd0;
      pronto <= 1'b0;
    end else begin
      // leds and pronto are registered alongside the state so they line up
      // with the state they belong to; the default is the blank value.
      leds   <= 7'd0;
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            limite_reg <= limite;
            endereco   <= 4'd0;
            estado     <= ENDERECA;
          end
        end
        ENDERECA: estado <= LE;
        LE: begin
          dado   <= mem_dado;
          leds   <= mem_dado;
          timer  <= 16'd0;
          estado <= ACENDE;
        end
        ACENDE: begin
          if (timer == TON_ULT) begin
            timer  <= 16'd0;
            estado <= APAGA;
          end else begin
            timer <= timer + 16'd1;
            leds  <= dado;
          end
        end
        APAGA: begin
          if (timer == TOFF_ULT) begin
            // Compare before incrementing so limite=15 never wraps to 0.
            if (endereco == limite_reg) begin
              pronto <= 1'b1;
              estado <= FIM;
            end else begin
              endereco <= endereco + 4'd1;
              estado   <= ENDERECA;
            end
          end else begin
            timer <= timer + 16'd1;
          end
        end
        FIM:     estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_reprodutor_sequencia.sv
// Bench for reprodutor_sequencia with T_ON=3, T_OFF=2: a slot-timing
// scoreboard per run, plus abort and asynchronous reset sequences.
module tb_reprodutor_sequencia;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       abortar = 1'b0;
  logic [3:0] limite = 4'd0;
  logic [3:0] mem_endereco;
  logic [6:0] mem_dado;
  logic [6:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [4:0] db_estado;

  reprodutor_sequencia #(.T_ON(3), .T_OFF(2)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
    .limite(limite), .mem_endereco(mem_endereco), .mem_dado(mem_dado),
    .leds(leds), .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  logic [6:0] mem [16];
  always @(posedge clock) mem_dado <= mem[mem_endereco];

  typedef logic [17:0] obs_t;
  obs_t dut_obs;
  assign dut_obs = {db_estado, leds, pronto, ocupado, mem_endereco};

  function automatic obs_t pack(logic [4:0] e, logic [6:0] l, logic p,
                                logic o, logic [3:0] a);
    return {e, l, p, o, a};
  endfunction

  obs_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_pat(input int p);
    for (int i = 0; i < 16; i++) begin
      case (p)
        0:       mem[i] = (i == 0) ? 7'h01 : (i == 1) ? 7'h40 : 7'h7F;
        1:       mem[i] = (i == 0) ? 7'h7F : 7'h2A;
        2:       mem[i] = 7'(i);
        default: mem[i] = (i % 2 == 1) ? 7'h00 : 7'(7'h55 ^ 7'(i));
      endcase
    end
  endtask

  // Expected per-cycle trace: 7-cycle slots (ENDERECA, LE, 3x ACENDE,
  // 2x APAGA), then FIM with pronto, then OCIOSO.
  task automatic push_trace(input logic [3:0] lim);
    int n, s, o;
    logic [4:0] e;
    logic [6:0] l;
    n = (int'(lim) + 1) * 7;
    for (int k = 0; k < n; k++) begin
      s = k / 7;
      o = k % 7;
      e = (o == 0) ? 5'd1 : (o == 1) ? 5'd2 : (o < 5) ? 5'd3 : 5'd4;
      l = (o >= 2 && o < 5) ? mem[s] : 7'd0;
      sb.push_back(pack(e, l, 1'b0, 1'b1, 4'(s)));
    end
    sb.push_back(pack(5'd5, 7'd0, 1'b1, 1'b1, lim));
    sb.push_back(pack(5'd0, 7'd0, 1'b0, 1'b0, lim));
  endtask

  // Plays one run; stops early (just after edge stop_k) when stop_k >= 0.
  task automatic play(input logic [3:0] lim, input bit disturb,
                      input int stop_k, output int pronto_k);
    int k;
    obs_t exp_o;
    pronto_k = -1;
    @(negedge clock);
    limite  = lim;
    iniciar = 1'b1;
    push_trace(lim);
    @(posedge clock); #1;
    iniciar = 1'b0;
    k = 0;
    while (sb.size() > 0) begin
      exp_o = sb.pop_front();
      check($sformatf("trace lim=%0d k=%0d", lim, k), 32'(dut_obs), 32'(exp_o));
      if (pronto && pronto_k < 0) pronto_k = k;
      if (k == stop_k) begin
        sb.delete();
        return;
      end
      if (disturb && k == 2) begin
        iniciar = 1'b1;
        limite  = 4'd5;
      end
      if (disturb && k == 3) iniciar = 1'b0;
      if (sb.size() > 0) begin
        @(posedge clock); #1;
        k++;
      end
    end
  endtask

  typedef struct {
    logic [3:0] lim;
    int         pat;
    bit         disturb;
    int         exp_pronto;
  } run_t;

  run_t runs [5];
  int pk, npr;

  initial begin
    runs[0] = '{lim: 4'd1,  pat: 0, disturb: 1'b0, exp_pronto: 14};
    runs[1] = '{lim: 4'd0,  pat: 1, disturb: 1'b0, exp_pronto: 7};
    runs[2] = '{lim: 4'd1,  pat: 0, disturb: 1'b1, exp_pronto: 14};
    runs[3] = '{lim: 4'd15, pat: 2, disturb: 1'b0, exp_pronto: 112};
    runs[4] = '{lim: 4'd3,  pat: 3, disturb: 1'b0, exp_pronto: 28};
    load_pat(0);

    #2 reset = 1'b0;
    #1 check("reset async", 32'(dut_obs), 32'd0);
    @(posedge clock); @(posedge clock); #1;
    check("reset held", 32'(dut_obs), 32'd0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    check("idle after release", 32'(dut_obs), 32'd0);

    for (int r = 0; r < 5; r++) begin
      load_pat(runs[r].pat);
      play(runs[r].lim, runs[r].disturb, -1, pk);
      check($sformatf("pronto cycle run %0d", r), 32'(pk), 32'(runs[r].exp_pronto));
      limite = 4'd0;
      repeat (2) @(posedge clock);
    end

    // Abort in the second ACENDE (k=9), with a simultaneous iniciar.
    load_pat(0);
    play(4'd1, 1'b0, 9, pk);
    abortar = 1'b1;
    iniciar = 1'b1;
    @(posedge clock); #1;
    abortar = 1'b0;
    iniciar = 1'b0;
    check("abort estado", 32'(db_estado), 32'd0);
    check("abort leds", 32'(leds), 32'd0);
    check("abort ocupado", 32'(ocupado), 32'd0);
    npr = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (pronto || ocupado) npr++;
    end
    check("abort no pronto", 32'(npr), 32'd0);

    // Asynchronous reset in the middle of the first APAGA (k=5).
    play(4'd1, 1'b0, 5, pk);
    #2 reset = 1'b0;
    #1 check("reset mid APAGA", 32'(dut_obs), 32'd0);
    @(posedge clock); #1;
    check("reset mid hold", 32'(dut_obs), 32'd0);
    @(negedge clock) reset = 1'b1;
    play(4'd1, 1'b0, -1, pk);
    check("pronto after reset", 32'(pk), 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
